brute_force_scheduler: RTL and testbench

- Run controller for a bank of NUM_WORKERS brute-force candidate generators (ASCII-counter chains plus per-worker match checkers).
- Partitions the keyspace by giving each worker a distinct starting character and a common stride equal to NUM_WORKERS.
- Sequences load, settle and run phases, enforces a cycle budget, and arbitrates simultaneous matches.
- Latches the winning password for the host-side interface.

---
 rtl/brute_force_scheduler.sv | 150 +++++++++++++++
 tb/tb_brute_force_scheduler.sv | 235 +++++++++++++++++++++++
 2 files changed

// File: rtl/brute_force_scheduler.sv
// rtl/brute_force_scheduler.sv - run controller for a bank of brute-force generator/checker workers
//
// Loads each worker with a distinct start character (char_base + i) and a
// common stride of NUM_WORKERS, holds them off for SETTLE_CYCLES, then runs
// them until a match, an exhausted cycle budget, or an abort.
//
// Ports:
//   clock, reset        rising-edge clock, synchronous active-high reset
//   start, abort        single-cycle host commands
//   char_base           first code of the alphabet
//   max_cycles          run budget in cycles, 0 = unlimited
//   worker_match        per-worker match flags
//   worker_password     per-worker candidates, 128 bits each
//   worker_enable       per-worker run enable
//   worker_start        per-worker start position, 8 bits each
//   worker_increment    common stride (constant NUM_WORKERS)
//   busy/found/done     status flags
//   found_password      captured winning candidate
//   found_worker        index of the winning worker
//   cycle_count         RUN cycles elapsed in the current or last search
module brute_force_scheduler #(
    parameter int NUM_WORKERS   = 4,
    parameter int WIDX          = 3,
    parameter int SETTLE_CYCLES = 2
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       start,
    input  logic                       abort,
    input  logic [7:0]                 char_base,
    input  logic [31:0]                max_cycles,
    input  logic [NUM_WORKERS-1:0]     worker_match,
    input  logic [128*NUM_WORKERS-1:0] worker_password,
    output logic [NUM_WORKERS-1:0]     worker_enable,
    output logic [8*NUM_WORKERS-1:0]   worker_start,
    output logic [2:0]                 worker_increment,
    output logic                       busy,
    output logic                       found,
    output logic                       done,
    output logic [127:0]               found_password,
    output logic [WIDX-1:0]            found_worker,
    output logic [31:0]                cycle_count
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_RUN,
        S_FOUND,
        S_EXHAUSTED
    } state_t;

    state_t state;
    state_t state_next;

    logic [3:0]             settle_cnt;
    logic [NUM_WORKERS-1:0] hits;
    logic                   any_hit;
    logic [WIDX-1:0]        win_idx;
    logic [127:0]           win_pw;
    logic                   budget_hit;
    logic                   settle_last;
    logic                   load_entry;

    assign worker_increment = 3'(NUM_WORKERS);

    // Matches only count from enabled workers; outside RUN the enables are low.
    assign hits    = worker_match & worker_enable;
    assign any_hit = |hits;

    // Scan high to low so the lowest set index is the last (winning) assignment.
    always_comb begin
        win_idx = '0;
        win_pw  = '0;
        for (int i = NUM_WORKERS - 1; i >= 0; i--) begin
            if (hits[i]) begin
                win_idx = WIDX'(i);
                win_pw  = worker_password[128*i +: 128];
            end
        end
    end

    // Compared against the pre-increment count, so the search ends with
    // cycle_count equal to max_cycles.
    assign budget_hit  = (max_cycles != 32'd0) && (cycle_count == max_cycles - 32'd1);
    assign settle_last = (settle_cnt == 4'(SETTLE_CYCLES - 1));

    always_comb begin
        state_next = state;
        case (state)
            S_IDLE, S_FOUND, S_EXHAUSTED: begin
                if (start) state_next = S_LOAD;
            end
            S_LOAD: begin
                if (abort)            state_next = S_IDLE;
                else if (settle_last) state_next = S_RUN;
            end
            S_RUN: begin
                if (abort)           state_next = S_IDLE;
                else if (any_hit)    state_next = S_FOUND;
                else if (budget_hit) state_next = S_EXHAUSTED;
            end
            default: state_next = S_IDLE;
        endcase
    end

    assign load_entry = (state_next == S_LOAD) && (state != S_LOAD);

    always_ff @(posedge clock) begin
        if (reset) begin
            state          <= S_IDLE;
            settle_cnt     <= '0;
            worker_enable  <= '0;
            worker_start   <= '0;
            busy           <= 1'b0;
            found          <= 1'b0;
            done           <= 1'b0;
            found_password <= '0;
            found_worker   <= '0;
            cycle_count    <= '0;
        end else begin
            state         <= state_next;
            worker_enable <= (state_next == S_RUN) ? '1 : '0;
            busy          <= (state_next == S_LOAD) || (state_next == S_RUN);
            found         <= (state_next == S_FOUND);
            done          <= (state_next == S_FOUND) || (state_next == S_EXHAUSTED);

            if (load_entry)
                settle_cnt <= '0;
            else if (state == S_LOAD)
                settle_cnt <= settle_cnt + 4'd1;

            if (load_entry) begin
                for (int i = 0; i < NUM_WORKERS; i++)
                    worker_start[8*i +: 8] <= char_base + 8'(i);
                cycle_count    <= '0;
                found_password <= '0;
                found_worker   <= '0;
            end else if (state == S_RUN && !abort) begin
                if (cycle_count != 32'hFFFF_FFFF)
                    cycle_count <= cycle_count + 32'd1;
                if (any_hit) begin
                    found_password <= win_pw;
                    found_worker   <= win_idx;
                end
            end
        end
    end

endmodule

// File: tb/tb_brute_force_scheduler.sv
// tb/tb_brute_force_scheduler.sv - self-checking bench for brute_force_scheduler
module tb_brute_force_scheduler;

    localparam int NW     = 4;
    localparam int WIDX   = 3;
    localparam int SETTLE = 2;

    logic              clock;
    logic              reset;
    logic              start;
    logic              abort;
    logic [7:0]        char_base;
    logic [31:0]       max_cycles;
    logic [NW-1:0]     worker_match;
    logic [128*NW-1:0] worker_password;
    logic [NW-1:0]     worker_enable;
    logic [8*NW-1:0]   worker_start;
    logic [2:0]        worker_increment;
    logic              busy;
    logic              found;
    logic              done;
    logic [127:0]      found_password;
    logic [WIDX-1:0]   found_worker;
    logic [31:0]       cycle_count;

    brute_force_scheduler #(
        .NUM_WORKERS  (NW),
        .WIDX         (WIDX),
        .SETTLE_CYCLES(SETTLE)
    ) dut (
        .clock           (clock),
        .reset           (reset),
        .start           (start),
        .abort           (abort),
        .char_base       (char_base),
        .max_cycles      (max_cycles),
        .worker_match    (worker_match),
        .worker_password (worker_password),
        .worker_enable   (worker_enable),
        .worker_start    (worker_start),
        .worker_increment(worker_increment),
        .busy            (busy),
        .found           (found),
        .done            (done),
        .found_password  (found_password),
        .found_worker    (found_worker),
        .cycle_count     (cycle_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    int errors = 0;
    int checks = 0;

    // Reference: mode 0 idle, 1 load, 2 run, 3 found, 4 exhausted.
    int          m_mode = 0;
    int          m_settle_left = 0;
    logic [8*NW-1:0] m_start = '0;
    logic [127:0]    m_pw = '0;
    int              m_w = 0;
    logic [31:0]     m_count = '0;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic [31:0] old;
        int idx;
        if (reset) begin
            m_mode = 0; m_start = '0; m_pw = '0; m_w = 0; m_count = '0; m_settle_left = 0;
        end else begin
            case (m_mode)
                0, 3, 4: if (start) begin
                    m_mode = 1;
                    m_settle_left = SETTLE;
                    for (int i = 0; i < NW; i++) m_start[8*i +: 8] = char_base + 8'(i);
                    m_count = '0; m_pw = '0; m_w = 0;
                end
                1: begin
                    if (abort) m_mode = 0;
                    else begin
                        m_settle_left--;
                        if (m_settle_left == 0) m_mode = 2;
                    end
                end
                2: begin
                    if (abort) m_mode = 0;
                    else begin
                        old = m_count;
                        if (m_count != 32'hFFFF_FFFF) m_count = m_count + 1;
                        idx = -1;
                        for (int i = NW - 1; i >= 0; i--) if (worker_match[i]) idx = i;
                        if (idx >= 0) begin
                            m_mode = 3;
                            m_w = idx;
                            m_pw = worker_password[128*idx +: 128];
                        end else if (max_cycles != 0 && old == max_cycles - 1) begin
                            m_mode = 4;
                        end
                    end
                end
                default: m_mode = 0;
            endcase
        end
    endtask

    task automatic compare_all();
        check("enable", 128'(worker_enable), (m_mode == 2) ? 128'hF : 128'h0);
        check("start_pos", 128'(worker_start), 128'(m_start));
        check("busy", 128'(busy), 128'(m_mode == 1 || m_mode == 2));
        check("found", 128'(found), 128'(m_mode == 3));
        check("done", 128'(done), 128'(m_mode == 3 || m_mode == 4));
        check("password", found_password, m_pw);
        check("worker", 128'(found_worker), 128'(m_w));
        check("count", 128'(cycle_count), 128'(m_count));
        check("increment", 128'(worker_increment), 128'(NW));
    endtask

    task automatic step();
        @(posedge clock);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic pulse_start();
        start = 1'b1; step(); start = 1'b0;
    endtask

    initial begin
        reset = 1'b1; start = 1'b0; abort = 1'b0; char_base = 8'h61;
        max_cycles = 32'd0; worker_match = '0; worker_password = '0;
        step(); step();
        reset = 1'b0;
        check("rst_busy", 128'(busy), 128'h0);
        check("rst_start_pos", 128'(worker_start), 128'h0);

        // Start from 'a' with unlimited budget.
        pulse_start();
        check("lit_start_pos", 128'(worker_start), 128'h64636261);
        check("lit_busy", 128'(busy), 128'h1);
        check("lit_en_load0", 128'(worker_enable), 128'h0);
        step();
        check("lit_en_load1", 128'(worker_enable), 128'h0);
        step();
        check("lit_en_run", 128'(worker_enable), 128'hF);
        for (int i = 0; i < 9; i++) step();
        worker_match = 4'b0100;
        worker_password[128*2 +: 128] = 128'h616263;
        step();
        worker_match = '0;
        check("lit_found", 128'(found), 128'h1);
        check("lit_done", 128'(done), 128'h1);
        check("lit_worker", 128'(found_worker), 128'h2);
        check("lit_pw", found_password, 128'h616263);
        check("lit_en_off", 128'(worker_enable), 128'h0);
        check("lit_count10", 128'(cycle_count), 128'd10);

        // Simultaneous matches: lowest index wins.
        pulse_start(); step(); step();
        worker_match = 4'b1010;
        worker_password[128*1 +: 128] = 128'h1111;
        worker_password[128*3 +: 128] = 128'h3333;
        step();
        worker_match = '0;
        check("lit_prio_worker", 128'(found_worker), 128'h1);
        check("lit_prio_pw", found_password, 128'h1111);

        // Budget of 5 cycles.
        max_cycles = 32'd5;
        pulse_start(); step(); step();
        for (int i = 0; i < 4; i++) step();
        check("lit_budget_busy", 128'(busy), 128'h1);
        step();
        check("lit_exh_done", 128'(done), 128'h1);
        check("lit_exh_found", 128'(found), 128'h0);
        check("lit_exh_count", 128'(cycle_count), 128'd5);
        max_cycles = 32'd0;
        pulse_start();
        check("lit_restart_done", 128'(done), 128'h0);
        check("lit_restart_busy", 128'(busy), 128'h1);

        // Abort beats match.
        step(); step();
        abort = 1'b1; worker_match = 4'hF;
        step();
        abort = 1'b0; worker_match = '0;
        check("lit_abort_found", 128'(found), 128'h0);
        check("lit_abort_done", 128'(done), 128'h0);
        check("lit_abort_en", 128'(worker_enable), 128'h0);
        check("lit_abort_busy", 128'(busy), 128'h0);

        // Start ignored while running, then reset mid-run.
        pulse_start(); step(); step(); step();
        pulse_start();
        check("lit_start_ignored", 128'(busy), 128'h1);
        reset = 1'b1; step(); reset = 1'b0;
        check("lit_rst_en", 128'(worker_enable), 128'h0);
        check("lit_rst_count", 128'(cycle_count), 128'h0);
        check("lit_rst_pos", 128'(worker_start), 128'h0);

        // Start-position wrap.
        char_base = 8'hFE;
        pulse_start();
        check("lit_wrap", 128'(worker_start), 128'h0100FFFE);

        // Randomized phase.
        for (int c = 0; c < 4000; c++) begin
            reset = ($urandom_range(0, 299) == 0);
            start = ($urandom_range(0, 14) == 0);
            abort = ($urandom_range(0, 39) == 0);
            worker_match = ($urandom_range(0, 9) == 0) ? NW'($urandom) : '0;
            for (int w = 0; w < NW; w++)
                worker_password[128*w +: 128] = {$urandom, $urandom, $urandom, $urandom};
            if (start) begin
                char_base  = 8'($urandom);
                max_cycles = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 25));
            end
            step();
        end
        reset = 1'b0; start = 1'b0; abort = 1'b0; worker_match = '0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
